// File: rtl/sha1_pkg.sv
// ---------------------------------------------------------------------------
// sha1_pkg
//   Shared definitions for the SHA-1 hardware path.
//   - pad_state_t  : state encoding of the padding/blocking front end
//   - SHA1_*       : block/word/length widths, padding marker, initial hash
//   - pad_marker() : builds the last partial word with the 0x80 marker
// ---------------------------------------------------------------------------
package sha1_pkg;

   localparam int SHA1_BLOCK_W = 512;
   localparam int SHA1_WORD_W  = 32;
   localparam int SHA1_LEN_W   = 64;
   localparam logic [SHA1_WORD_W-1:0] SHA1_PAD_WORD = 32'h8000_0000;

   // Initial chaining value, consumed by the downstream chaining controller.
   localparam logic [159:0] SHA1_IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_PAD,
      ST_SEND,
      ST_WAIT
   } pad_state_t;

   // Keep the nb leading message bytes, put 0x80 right after them and zero
   // the rest. nb=0 degenerates to a bare marker word; nb>=4 passes through.
   function automatic logic [SHA1_WORD_W-1:0] pad_marker(
      input logic [SHA1_WORD_W-1:0] w,
      input logic [2:0]             nb
   );
      case (nb)
         3'd0:    return SHA1_PAD_WORD;
         3'd1:    return {w[31:24], 8'h80, 16'h0000};
         3'd2:    return {w[31:16], 8'h80, 8'h00};
         3'd3:    return {w[31:8], 8'h80};
         default: return w;
      endcase
   endfunction

endpackage

// File: rtl/sha1_pad_block.sv
// ---------------------------------------------------------------------------
// sha1_pad_block
//   Packs a big-endian 32-bit message word stream into 512-bit SHA-1 blocks,
//   appends the 0x80 marker, zero fill and the 64-bit bit length, and hands
//   each block to sha1_update via a start/done handshake.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   in_valid     : message word valid
//   in_ready     : word accepted this cycle (only while filling)
//   in_data      : message word, first byte in [31:24]
//   in_bytes     : valid bytes (left-justified), 0 only for an empty tail
//   in_last      : final word of the message
//   block_data   : 512-bit block, word 0 in [511:480], stable until done
//   block_start  : one-cycle pulse, block_data valid
//   block_last   : with block_start, block carries the length field
//   block_done   : sha1_update consumed the block
// ---------------------------------------------------------------------------
module sha1_pad_block
   import sha1_pkg::*;
#(
   parameter int LEN_W = SHA1_LEN_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SHA1_WORD_W-1:0]  in_data,
   input  logic [2:0]              in_bytes,
   input  logic                    in_last,
   output logic [SHA1_BLOCK_W-1:0] block_data,
   output logic                    block_start,
   output logic                    block_last,
   input  logic                    block_done
);

   pad_state_t state_q, state_d;

   // Word i of the block lives at blk_q[15-i] so that word 0 lands in the
   // top bits of the packed vector; 15-w is simply ~w on 4 bits.
   logic [15:0][SHA1_WORD_W-1:0] blk_q;
   logic [4:0]                   w_q;        // next word index, 0..16
   logic [LEN_W-1:0]             cnt_q;      // message length in bits
   logic                         pad_pend_q; // 0x80 marker still owed
   logic                         last_q;     // length field is in blk_q
   logic                         msg_end_q;  // in_last already seen

   logic accept;
   logic len_now;   // PAD cycle that writes the length words
   logic full;

   assign accept  = in_valid && (state_q == ST_FILL);
   assign full    = (w_q == 5'd16);
   assign len_now = (w_q == 5'd14) && !pad_pend_q;

   // -------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_FILL;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (in_last)             state_d = ST_PAD;
               else if (w_q == 5'd15)   state_d = ST_SEND;
            end
         end
         ST_PAD: begin
            if (full || len_now) state_d = ST_SEND;
         end
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            if (block_done) begin
               if (last_q)          state_d = ST_FILL;
               else if (msg_end_q)  state_d = ST_PAD;
               else                 state_d = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // Gated by rst_n so every output reads 0 while reset is held, even before
   // the first clock edge of the reset has cleared the registers.
   always_comb begin
      in_ready    = rst_n && (state_q == ST_FILL);
      block_start = rst_n && (state_q == ST_SEND);
      block_last  = rst_n && (state_q == ST_SEND) && last_q;
   end

   assign block_data = rst_n ? blk_q : '0;

   // --------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blk_q      <= '0;
         w_q        <= '0;
         cnt_q      <= '0;
         pad_pend_q <= 1'b0;
         last_q     <= 1'b0;
         msg_end_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  cnt_q <= cnt_q + LEN_W'({in_bytes, 3'b000});
                  if (in_last) begin
                     msg_end_q  <= 1'b1;
                     pad_pend_q <= (in_bytes == 3'd0) || (in_bytes >= 3'd4);
                  end
                  // An empty tail carries no data and occupies no slot.
                  if (!(in_last && in_bytes == 3'd0)) begin
                     blk_q[~w_q[3:0]] <= (in_last && in_bytes < 3'd4)
                                         ? pad_marker(in_data, in_bytes)
                                         : in_data;
                     w_q <= w_q + 5'd1;
                  end
               end
            end
            ST_PAD: begin
               if (len_now) begin
                  blk_q[1] <= cnt_q[LEN_W-1 -: 32];
                  blk_q[0] <= cnt_q[31:0];
                  last_q   <= 1'b1;
               end else if (!full) begin
                  // Also covers w==15: no room for the length, fill and spill.
                  blk_q[~w_q[3:0]] <= pad_pend_q ? SHA1_PAD_WORD : '0;
                  pad_pend_q       <= 1'b0;
                  w_q              <= w_q + 5'd1;
               end
            end
            ST_WAIT: begin
               if (block_done) begin
                  w_q   <= '0;
                  blk_q <= '0;
                  if (last_q) begin
                     cnt_q     <= '0;
                     last_q    <= 1'b0;
                     msg_end_q <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_pad_block.sv
module tb_sha1_pad_block;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic [2:0]   in_bytes;
   logic         in_last;
   logic [511:0] block_data;
   logic         block_start;
   logic         block_last;
   logic         block_done;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [7:0]   msg_q[$];      // message under test, byte stream
   logic [511:0] obs_blk[$];    // blocks observed during the last message
   logic [511:0] abc_blk;

   always #5 clk = ~clk;

   sha1_pad_block dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_bytes   (in_bytes),
      .in_last    (in_last),
      .block_data (block_data),
      .block_start(block_start),
      .block_last (block_last),
      .block_done (block_done)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wordof(input logic [511:0] b, input int i);
      return b[511-32*i -: 32];
   endfunction

   // Reference: textbook SHA-1 padding on a byte list, then cut into blocks.
   task automatic build_expected(output logic [511:0] exp_q[$]);
      logic [7:0]  pad[$];
      logic [63:0] bitlen;
      logic [511:0] b;
      exp_q.delete();
      pad = msg_q;
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      bitlen = 64'(msg_q.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
      for (int k = 0; k < pad.size() / 64; k++) begin
         b = '0;
         for (int j = 0; j < 64; j++) b[511-8*j -: 8] = pad[64*k + j];
         exp_q.push_back(b);
      end
   endtask

   // Entered and left #1 after a rising edge. Streams msg_q, acknowledges each
   // block done_dly cycles after its start, checks every block.
   task automatic run_message(input string tag, input int done_dly,
                              input bit gaps, input bit empty_tail);
      logic [511:0] exp_q[$];
      logic [31:0]  wd[$];
      logic [2:0]   wb[$];
      logic [31:0]  word;
      logic [511:0] held;
      int  n, nb, widx, nblk, dcnt, budget;
      bit  waiting, stable_ok;
      build_expected(exp_q);
      obs_blk.delete();
      n = msg_q.size();
      for (int i = 0; i < n; i += 4) begin
         word = $urandom;   // bytes past the message end are garbage
         nb   = 0;
         for (int j = 0; j < 4; j++)
            if (i + j < n) begin word[31-8*j -: 8] = msg_q[i+j]; nb++; end
         wd.push_back(word);
         wb.push_back(3'(nb));
      end
      if (n == 0 || (empty_tail && n % 4 == 0)) begin
         wd.push_back($urandom);
         wb.push_back(3'd0);
      end
      widx = 0; nblk = 0; dcnt = 0; budget = 0;
      waiting = 0; stable_ok = 1; held = '0;
      while (1) begin
         block_done = 1'b0;
         if (widx == wd.size() && nblk == exp_q.size() && !waiting) break;
         if (++budget > 5000) begin
            chk({tag, "_timeout"}, 512'(nblk), 512'(exp_q.size() + 1000));
            break;
         end
         if (block_start) begin
            obs_blk.push_back(block_data);
            if (nblk < exp_q.size()) begin
               chk({tag, "_data"}, block_data, exp_q[nblk]);
               chk({tag, "_last"}, 512'(block_last), 512'(nblk == exp_q.size() - 1));
            end else begin
               chk({tag, "_extra_block"}, 512'(nblk + 1), 512'(exp_q.size()));
            end
            if (in_ready !== 1'b0) stable_ok = 0;
            held = block_data; waiting = 1; dcnt = done_dly; nblk++;
         end else if (waiting) begin
            if (block_data !== held || in_ready !== 1'b0) stable_ok = 0;
            if (--dcnt == 0) begin
               block_done = 1'b1;
               waiting    = 0;
               chk({tag, "_hold"}, 512'(stable_ok), 512'(1));
               stable_ok  = 1;
            end
         end
         if (widx < wd.size() && in_ready && (!gaps || $urandom_range(3) != 0)) begin
            in_valid = 1'b1; in_data = wd[widx]; in_bytes = wb[widx];
            in_last  = (widx == wd.size() - 1); widx++;
         end else begin
            // While not ready, occasionally wave junk that must be ignored.
            in_valid = gaps && !in_ready && $urandom_range(1) == 1;
            in_data  = $urandom; in_bytes = 3'(4); in_last = $urandom_range(1) == 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk({tag, "_nblk"}, 512'(nblk), 512'(exp_q.size()));
      chk({tag, "_back_to_fill"}, 512'(in_ready), 512'(1));
   endtask

   initial begin
      string s;
      int    cyc;
      logic [511:0] b;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bytes = '0;
      in_last = 1'b0; block_done = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("rst_in_ready", 512'(in_ready), 512'(0));
      chk("rst_start",    512'(block_start), 512'(0));
      chk("rst_data",     block_data, 512'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 512'(in_ready), 512'(1));

      // Empty message
      msg_q.delete();
      run_message("empty", 1, 0, 0);
      b = obs_blk[0];
      chk("empty_w0", 512'(wordof(b, 0)), 512'(32'h8000_0000));
      chk("empty_rest", 512'(b[479:0]), 512'(0));

      // "abc"
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_message("abc", 2, 0, 0);
      abc_blk = obs_blk[0];
      chk("abc_w0",  512'(wordof(abc_blk, 0)),  512'(32'h6162_6380));
      chk("abc_w15", 512'(wordof(abc_blk, 15)), 512'(32'h0000_0018));

      // 56 bytes: length spills into a second block
      s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      msg_q.delete();
      for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
      run_message("m56", 3, 1, 0);
      b = obs_blk[0];
      chk("m56_b1_w14", 512'(wordof(b, 14)), 512'(32'h8000_0000));
      b = obs_blk[1];
      chk("m56_b2_w15", 512'(wordof(b, 15)), 512'(32'h0000_01C0));

      // 64 bytes, ended on a full word and then via an empty tail
      for (int t = 0; t < 2; t++) begin
         msg_q.delete();
         for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom_range(255)));
         run_message(t == 0 ? "m64" : "m64_tail", 2, t == 1, t == 1);
         b = obs_blk[1];
         chk("m64_b2_w0",  512'(wordof(b, 0)),  512'(32'h8000_0000));
         chk("m64_b2_w15", 512'(wordof(b, 15)), 512'(32'h0000_0200));
      end

      // Stray done while filling, then a slow consumer
      block_done = 1'b1;
      @(posedge clk); #1;
      block_done = 1'b0;
      chk("stray_start", 512'(block_start), 512'(0));
      chk("stray_ready", 512'(in_ready), 512'(1));
      msg_q.delete();
      for (int i = 0; i < 30; i++) msg_q.push_back(8'($urandom_range(255)));
      run_message("slow", 100, 0, 0);

      // Random messages
      for (int r = 0; r < 20; r++) begin
         msg_q.delete();
         cyc = $urandom_range(150);
         for (int i = 0; i < cyc; i++) msg_q.push_back(8'($urandom_range(255)));
         run_message("rand", $urandom_range(1, 8), 1, $urandom_range(1) == 1);
      end

      // Reset while waiting on a block, then a late done, then "abc" again
      in_valid = 1'b1; in_data = 32'h6162_63A5; in_bytes = 3'd3; in_last = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      cyc = 0;
      while (!block_start && cyc < 100) begin @(posedge clk); #1; cyc++; end
      chk("abort_start", 512'(block_start), 512'(1));
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_rst_data", block_data, 512'(0));
      @(posedge clk); #1;
      chk("abort_rst_ready", 512'(in_ready), 512'(0));
      chk("abort_rst_start", 512'(block_start), 512'(0));
      chk("abort_rst_last",  512'(block_last), 512'(0));
      chk("abort_rst_data2", block_data, 512'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      block_done = 1'b1;
      @(posedge clk); #1;
      block_done = 1'b0;
      chk("late_done_start", 512'(block_start), 512'(0));
      chk("late_done_ready", 512'(in_ready), 512'(1));
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_message("abc_again", 4, 0, 0);
      chk("abc_again_same", obs_blk[0], abc_blk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/sha1_pad_block.md
Name: sha1_pad_block

Overview:
- Upstream stage of sha1_update. Accepts an arbitrary-length message as a 32-bit big-endian word stream.
- Assembles it into 512-bit blocks and appends standard SHA-1 padding: 0x80 marker, zero fill, and 64-bit big-endian bit length.
- Hands each block to sha1_update through its start/done handshake.
- Replaces the software padding currently done in the bench, so the whole hash path runs in hardware.

Parameters:
- LEN_W, 64, width of the message bit-length counter; fixed at 64 by SHA-1, exposed for lint only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  32  message word; first byte in [31:24]
- in_bytes  in  3  valid bytes in word, left-justified; must be 4 unless in_last; 0 allowed only with in_last (empty tail)
- in_last  in  1  final word of message
- block_data  out  512  block to sha1_update data_in; word 0 in [511:480]
- block_start  out  1  one-cycle pulse, block_data valid
- block_last  out  1  high with block_data when the block carries the length field
- block_done  in  1  sha1_update done; block consumed

Behaviour:
- Reset: all outputs 0. FSM=FILL, word index w=0, bit count=0, pad_pending=0, buffer cleared. Reset applies in any state, including mid-WAIT; a block in flight is abandoned and any later block_done is ignored.
- States: FILL, PAD, SEND, WAIT.
- FILL:
  - in_ready=1. On in_valid&in_ready, write a word at index w, w++, bit count += 8*in_bytes (wraps mod 2^64, no error).
  - Non-last word with w becomes 16: go to SEND.
  - Last word with in_bytes 1..3: byte in_bytes of the word becomes 0x80, lower bytes become 0x00.
  - Last word with in_bytes 4: pad_pending=1.
  - Last word with in_bytes 0: no word is written, w unchanged, pad_pending=1.
  - After a last word, go to PAD.
- PAD:
  - in_ready=0. One word per cycle.
  - If w<14: write word w = pad_pending ? 0x80000000 : 0; clear pad_pending; w++.
  - If w==14 and pad_pending=0: in one cycle write words 14/15 = count[63:32] / count[31:0], set last flag, go to SEND.
  - If w==14 and pad_pending=1: write word 14 = 0x80000000, clear pad_pending, w++.
  - If w reaches 16 without the length written: go to SEND with last flag clear; PAD resumes afterwards.
- SEND: block_start=1 for exactly one cycle, block_last=last flag, then go to WAIT.
- WAIT:
  - block_data held stable; in_ready=0.
  - On block_done: clear w and the buffer.
    - Length already sent: clear count and last flag, go to FILL.
    - Else if the message has ended: go to PAD.
    - Else: go to FILL.
- block_done outside WAIT is ignored. block_done in the same cycle as block_start cannot occur, because sha1_update latency is at least 1.
- Block counts:
  - 0..55-byte messages produce 1 padding block.
  - 56..63 bytes (tail in one block) produce 2 blocks.
  - An exact multiple of 64 bytes produces a final block of 0x80000000, zeros and the length.
- Throughput: one word per cycle in FILL; no input accepted while PAD/SEND/WAIT.

Decomposition:
- sha1_pkg holds:
  - the FSM state enum;
  - SHA1_BLOCK_W=512, SHA1_WORD_W=32, SHA1_LEN_W=64, SHA1_PAD_WORD=32'h80000000;
  - SHA1_IV=160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0, for the downstream chaining controller.
- No sub-module required. Buffer, counter and FSM stay inline; the marker-insert mux may be a function in sha1_pkg.

Test Plan:
- Empty message (in_last, in_bytes=0) -> one block: word0=0x80000000, words1..15=0, block_last=1.
- "abc" (0x61626300, in_bytes=3, last) -> word0=0x61626380, word15=0x00000018, block_last=1. With sha1_update chained from SHA1_IV, digest=a9993e364706816aba3e25717850c26c9cd0d89d.
- 56-byte message ("abcdbcde...nopq") -> two blocks:
  - block1 word14=0x80000000, block_last=0;
  - block2 words0..13=0, word15=0x000001C0, block_last=1;
  - digest 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- 64-byte message -> block1 pure data with block_last=0; block2 word0=0x80000000, word15=0x00000200, block_last=1.
- block_done delayed 100 cycles -> block_start pulses once, block_data stable, in_ready=0 throughout; a stray block_done in FILL has no effect.
- rst_n low during WAIT, then a new "abc" -> outputs 0 during reset; next block identical to the "abc" case; late block_done from the aborted block ignored.
